alu_op_driver: RTL
==================

# alu_op_driver

Command-side initiator for the 4-bit tile ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. Each command is driven onto the ALU's operand and opcode pins, the registered result and flags are sampled after the ALU latency, and the capture is returned over a second valid/ready handshake. It also decodes ENC results back to plaintext and checks them, and flags unsupported opcodes.

## Interface
- FIFO_DEPTH, 4: command FIFO entries (power of two, ≥2)
- ALU_LATENCY, 1: ALU clock cycles from operands-stable to result-valid
- ENC_KEY, 8'hAB: XOR key used by the ALU ENC opcode
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO not full
- cmd_a  input  4  operand a
- cmd_b  input  4  operand b
- cmd_op  input  4  opcode (0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 ENC)
- alu_ui_in  output  8  {a,b} to ALU ui_in
- alu_uio_in  output  8  {4'b0,op} to ALU uio_in
- alu_uo_out  input  8  ALU result
- alu_uio_out  input  8  ALU flags: [7] overflow, [6] carry
- rsp_valid  output  1  response held
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  8  captured alu_uo_out
- rsp_carry  output  1  captured alu_uio_out[6]
- rsp_overflow  output  1  captured alu_uio_out[7]
- rsp_op  output  4  opcode of this response
- rsp_err  output  1  opcode > 8
- rsp_mismatch  output  1  op==8 and (rsp_result ^ ENC_KEY) != {a,b}
- busy  output  1  state != IDLE or FIFO non-empty

## Operation
- FIFO: push on cmd_valid && cmd_ready, storing {a,b,op}. cmd_ready = (count < FIFO_DEPTH) from the registered count. Pop only in the FSM cases listed below. Count range is 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH. A same-cycle push and pop leaves count unchanged.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if FIFO non-empty, pop into the drive register and go to ISSUE. Otherwise stay.
  - ISSUE: alu_ui_in/alu_uio_in show the drive register. Stay ALU_LATENCY cycles (down-counter), then go to CAPTURE.
  - CAPTURE: drive values stay held. At the end of the cycle, sample alu_uo_out, alu_uio_out[7:6], op, err and mismatch into the response registers. Go to RESP.
  - RESP: rsp_valid=1 and all rsp_* stable until the rsp_valid && rsp_ready edge. On that edge, if FIFO non-empty, pop and go to ISSUE (back-to-back). Otherwise go to IDLE.
- Idle drive pattern: when not in ISSUE/CAPTURE, alu_ui_in=8'h00 and alu_uio_in=8'h0F. The ALU default case then yields zeros.
- Every opcode is issued to the ALU, including invalid ones. rsp_err is set when op > 8, and the ALU then returns 0. rsp_mismatch is 0 for non-ENC ops.
- Reset (any state, including mid-operation): FIFO emptied, in-flight command dropped, state=IDLE. Outputs after reset: cmd_ready=1, rsp_valid=0, all rsp_* =0, alu_ui_in=8'h00, alu_uio_in=8'h0F, busy=0.

## Timing
- Command accepted at edge T into an empty FIFO with state IDLE:
  - T+1: pop.
  - T+2 … T+1+ALU_LATENCY: ISSUE.
  - Next cycle: CAPTURE.
  - rsp_valid first high at cycle T+3+ALU_LATENCY (T+4 at default).
- Back-to-back throughput with rsp_ready held high: one response per ALU_LATENCY+2 cycles.
- rsp_valid never drops without a handshake, except on reset.
- Up to FIFO_DEPTH commands plus one in flight are accepted while rsp_ready=0.

## Test plan
- Reset: hold rst 2 cycles, then check every output equals its reset value. Check cmd_ready=1 in the first cycle after release.
- ADD a=7 b=9 (op 0) with rsp_ready=1 -> rsp_valid at accept+4, rsp_result=8'h00, rsp_carry=1, rsp_overflow=0, rsp_err=0.
- SUB a=3 b=5 (op 1) -> rsp_result=8'h0E, rsp_carry=1, rsp_overflow=0. Then ENC a=1 b=2 (op 8) -> rsp_result=8'hB9, rsp_mismatch=0. Force alu_uo_out to 8'hB8 during CAPTURE -> rsp_mismatch=1.
- Backpressure: rsp_ready=0, offer 7 commands -> exactly 5 accepted, cmd_ready low with count=4. Response 1 is stable for 20 cycles. Release rsp_ready -> 5 responses arrive in order, 3 cycles apart.
- Invalid op 4'hC, a=F b=F -> rsp_result=0, rsp_err=1, flags 0.
- Assert rst during ISSUE with 2 commands queued -> next cycle state IDLE, busy=0, rsp_valid=0, and no response for the dropped commands ever appears.

Source files
------------

// File: rtl/alu_op_driver_if.sv
// Bundle of command, response and ALU pin signals for alu_op_driver.
// The slave modport is the driver's own view; master is the environment (command source, consumer, ALU).
interface alu_op_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_op;
  logic [7:0] alu_ui_in;
  logic [7:0] alu_uio_in;
  logic [7:0] alu_uo_out;
  logic [7:0] alu_uio_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_overflow;
  logic [3:0] rsp_op;
  logic       rsp_err;
  logic       rsp_mismatch;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_uo_out, alu_uio_out,
    output cmd_ready, alu_ui_in, alu_uio_in, rsp_valid, rsp_result, rsp_carry,
           rsp_overflow, rsp_op, rsp_err, rsp_mismatch, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_uo_out, alu_uio_out,
    input  cmd_ready, alu_ui_in, alu_uio_in, rsp_valid, rsp_result, rsp_carry,
           rsp_overflow, rsp_op, rsp_err, rsp_mismatch, busy
  );
endinterface

// File: rtl/alu_op_driver.sv
// Command-side initiator for the 4-bit tile ALU: buffers commands, drives the ALU pins,
// captures the registered result after the ALU latency and hands it back with decode checks.
module alu_op_driver #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          ALU_LATENCY = 1,
  parameter logic [7:0]  ENC_KEY     = 8'hAB
) (
  input  logic           clk,
  input  logic           rst,
  alu_op_driver_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] lat_cnt;
  logic          push, pop, fifo_empty;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [3:0]    drv_a_p0, drv_b_p0, drv_op_p0;
  logic          driving;

  logic [7:0]    rsp_result_p1;
  logic          rsp_carry_p1, rsp_overflow_p1, rsp_err_p1, rsp_mismatch_p1;
  logic [3:0]    rsp_op_p1;

  logic          unused_flags;

  function automatic logic enc_mismatch(input logic [3:0] op, input logic [7:0] res,
                                        input logic [7:0] ab);
    return (op == 4'd8) && ((res ^ ENC_KEY) != ab);
  endfunction

  function automatic logic op_invalid(input logic [3:0] op);
    return op > 4'd8;
  endfunction

  assign bus.cmd_ready = (count < CW'(FIFO_DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign fifo_empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop)
        lat_cnt <= LW'(ALU_LATENCY - 1);
      else if (state == ISSUE && lat_cnt != '0)
        lat_cnt <= lat_cnt - LW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_cnt == '0) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- drive stage: command held on the ALU pins through ISSUE and CAPTURE
  always_ff @(posedge clk) begin
    if (pop) {drv_a_p0, drv_b_p0, drv_op_p0} <= mem[rd_ptr];
  end

  assign driving        = (state == ISSUE) || (state == CAPTURE);
  assign bus.alu_ui_in  = driving ? {drv_a_p0, drv_b_p0} : 8'h00;
  assign bus.alu_uio_in = driving ? {4'b0000, drv_op_p0} : 8'h0F;

  // ---- capture stage: response registers, cleared on reset so rsp_* read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result_p1   <= '0;
      rsp_carry_p1    <= 1'b0;
      rsp_overflow_p1 <= 1'b0;
      rsp_op_p1       <= '0;
      rsp_err_p1      <= 1'b0;
      rsp_mismatch_p1 <= 1'b0;
    end else if (state == CAPTURE) begin
      rsp_result_p1   <= bus.alu_uo_out;
      rsp_carry_p1    <= bus.alu_uio_out[6];
      rsp_overflow_p1 <= bus.alu_uio_out[7];
      rsp_op_p1       <= drv_op_p0;
      rsp_err_p1      <= op_invalid(drv_op_p0);
      rsp_mismatch_p1 <= enc_mismatch(drv_op_p0, bus.alu_uo_out, {drv_a_p0, drv_b_p0});
    end
  end

  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_result   = rsp_result_p1;
  assign bus.rsp_carry    = rsp_carry_p1;
  assign bus.rsp_overflow = rsp_overflow_p1;
  assign bus.rsp_op       = rsp_op_p1;
  assign bus.rsp_err      = rsp_err_p1;
  assign bus.rsp_mismatch = rsp_mismatch_p1;
  assign bus.busy         = (state != IDLE) || !fifo_empty;

  // Only the two top flag bits carry meaning on this ALU.
  assign unused_flags = ^bus.alu_uio_out[5:0];

endmodule
